// File: rtl/spi_master_tx_multi_cs.sv
// SPI mode-0 master transmitter: buffered words go out MSB-first to one of NUM_CS active-low selects.
// Optional feature macro SPI_TX_FIFO_EN: FIFO_DEPTH-entry input FIFO instead of a single holding register.
module spi_master_tx_multi_cs #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 4,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int CS_SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [CS_SEL_W-1:0]   cs_sel_i,
  input  logic                  data_in_valid_strobe_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  error_o,
  output logic                  spi_clk_o,
  output logic                  spi_mosi_o,
  output logic [NUM_CS-1:0]     spi_cs_o
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]    BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CS_SEL_W:0]   NUM_CS_L = (CS_SEL_W + 1)'(NUM_CS);

  state_t                state, state_next;
  logic [DIV_W-1:0]      div_cnt, div_next;
  logic [BIT_W-1:0]      bit_cnt, bit_next;
  logic [DATA_WIDTH-1:0] shreg, shreg_next;
  logic                  sclk, sclk_next;
  logic                  mosi, mosi_next;
  logic [NUM_CS-1:0]     cs_n, cs_next, sel_onehot;
  logic                  ready, ready_next;
  logic                  busy, busy_next;
  logic                  error, error_next;
  logic                  sel_ok, push, pop, load, div_done;
  logic                  non_empty, non_empty_next;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CS_SEL_W-1:0]   head_sel;

  assign sel_ok = ({1'b0, cs_sel_i} < NUM_CS_L);
  // ready is the registered "not full" flag, so a full buffer rejects even when a pop coincides
  assign push   = data_in_valid_strobe_i & ready & sel_ok & ~rst_i;
  assign pop    = load;

`ifdef SPI_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [CS_SEL_W-1:0]   mem_sel  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count, count_next;

  assign non_empty = (count != {(PTR_W + 1){1'b0}});
  assign head_data = mem_data[rd_ptr];
  assign head_sel  = mem_sel[rd_ptr];

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + (PTR_W + 1)'(1);
    end else if (pop && !push) begin
      count_next = count - (PTR_W + 1)'(1);
    end else begin
      count_next = count;
    end
  end

  assign non_empty_next = (count_next != {(PTR_W + 1){1'b0}});
  assign ready_next     = (count_next != DEPTH_L);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= data_i;
      mem_sel[wr_ptr]  <= cs_sel_i;
    end
  end
`else
  logic hold_full;

  assign non_empty = hold_full;
  // push needs an empty register and pop needs a full one, so they never coincide
  assign non_empty_next = push | (hold_full & ~pop);
  assign ready_next     = ~non_empty_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_full <= 1'b0;
      head_data <= '0;
      head_sel  <= '0;
    end else begin
      hold_full <= non_empty_next;
      if (push) begin
        head_data <= data_i;
        head_sel  <= cs_sel_i;
      end
    end
  end
`endif

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      sel_onehot[i] = (head_sel == CS_SEL_W'(i));
    end
  end

  assign div_done = (div_cnt == DIV_LAST);

  always_comb begin
    state_next = state;
    div_next   = div_cnt;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    sclk_next  = sclk;
    mosi_next  = mosi;
    cs_next    = cs_n;
    load       = 1'b0;
    case (state)
      IDLE: begin
        load = non_empty;
      end
      SETUP: begin
        if (div_done) begin
          state_next = SHIFT;
          sclk_next  = 1'b1;
          div_next   = '0;
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
      end
      SHIFT: begin
        if (!div_done) begin
          div_next = div_cnt + DIV_W'(1);
        end else if (sclk) begin
          // falling edge: present the next bit unless this was the last one
          div_next  = '0;
          sclk_next = 1'b0;
          if (bit_cnt != BIT_LAST) begin
            mosi_next  = shreg[DATA_WIDTH-2];
            shreg_next = {shreg[DATA_WIDTH-2:0], 1'b0};
          end else begin
            mosi_next = mosi;
          end
        end else if (bit_cnt == BIT_LAST) begin
          div_next   = '0;
          state_next = HOLD;
        end else begin
          div_next  = '0;
          sclk_next = 1'b1;
          bit_next  = bit_cnt + BIT_W'(1);
        end
      end
      HOLD: begin
        if (div_done) begin
          div_next   = '0;
          cs_next    = '1;
          state_next = GAP;
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
      end
      GAP: begin
        if (div_done) begin
          div_next   = '0;
          load       = non_empty;
          state_next = IDLE;
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cs_next    = '1;
        sclk_next  = 1'b0;
      end
    endcase
    if (load) begin
      state_next = SETUP;
      shreg_next = head_data;
      mosi_next  = head_data[DATA_WIDTH-1];
      cs_next    = ~sel_onehot;
      div_next   = '0;
      bit_next   = '0;
    end else begin
      state_next = state_next;
    end
  end

  assign busy_next  = (state_next != IDLE) | non_empty_next;
  assign error_next = data_in_valid_strobe_i & ~(ready & sel_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= '1;
      ready   <= 1'b1;
      busy    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_next;
      div_cnt <= div_next;
      bit_cnt <= bit_next;
      shreg   <= shreg_next;
      sclk    <= sclk_next;
      mosi    <= mosi_next;
      cs_n    <= cs_next;
      ready   <= ready_next;
      busy    <= busy_next;
      error   <= error_next;
    end
  end

  assign ready_o    = ready;
  assign busy_o     = busy;
  assign error_o    = error;
  assign spi_clk_o  = sclk;
  assign spi_mosi_o = mosi;
  assign spi_cs_o   = cs_n;

endmodule

// File: tb/tb_spi_master_tx_multi_cs.sv
// Directed bench for spi_master_tx_multi_cs; expectations follow the SPI_TX_FIFO_EN build setting.
module tb_spi_master_tx_multi_cs;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic [1:0] sel = 2'd0;
  logic       strobe = 1'b0, strobe3 = 1'b0;
  logic       ready, busy, error, sclk, mosi;
  logic [3:0] cs;
  logic       ready3, busy3, error3, sclk3, mosi3;
  logic [2:0] cs3;
  int errors = 0;
  int checks = 0;

  spi_master_tx_multi_cs dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .cs_sel_i(sel),
    .data_in_valid_strobe_i(strobe), .ready_o(ready), .busy_o(busy), .error_o(error),
    .spi_clk_o(sclk), .spi_mosi_o(mosi), .spi_cs_o(cs));

  spi_master_tx_multi_cs #(.NUM_CS(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .cs_sel_i(sel),
    .data_in_valid_strobe_i(strobe3), .ready_o(ready3), .busy_o(busy3), .error_o(error3),
    .spi_clk_o(sclk3), .spi_mosi_o(mosi3), .spi_cs_o(cs3));

  // Frame recorder: one entry per CS-low stretch, with bits captured on SCLK rises
  typedef struct {
    logic [3:0] cs;
    logic [7:0] bits;
    int         nbits;
    int         len;
    int         gap;
  } frame_t;
  frame_t frames[$];
  frame_t cur;
  bit in_frame = 1'b0, have_prev = 1'b0, prev_sclk = 1'b0, prev_mosi = 1'b0;
  int high_cnt = 0, glitches = 0, multi_low = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
        have_prev = 1'b0;
      end else if (cs != 4'hF) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          cur.cs = cs; cur.bits = 8'h00; cur.nbits = 0; cur.len = 0;
          cur.gap = have_prev ? high_cnt : -1;
        end
        cur.len++;
        if (cs != cur.cs) multi_low++;
        if (sclk && !prev_sclk) begin
          cur.bits = {cur.bits[6:0], mosi};
          cur.nbits++;
        end
        if (sclk && prev_sclk && (mosi != prev_mosi)) glitches++;
      end else begin
        if (in_frame) begin
          frames.push_back(cur);
          in_frame = 1'b0;
          have_prev = 1'b1;
          high_cnt = 0;
        end
        high_cnt++;
        if (sclk) glitches++;
      end
      if ($countones(~cs) > 1) multi_low++;
      prev_sclk = sclk;
      prev_mosi = mosi;
    end
  end

  task automatic clear_mon();
    frames.delete();
    have_prev = 1'b0;
    glitches = 0;
    multi_low = 0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int k = 0;
    while (frames.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (frames.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1; strobe = 1'b1; data = 8'h5A; sel = 2'd1;
    repeat (3) @(negedge clk);
    checks++; if (cs !== 4'hF) begin errors++; $display("FAIL reset_cs: got %b want 1111", cs); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
    rst = 1'b0; strobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int n = 0;
    bit ok;
    clear_mon();
    data = 8'hA5; sel = 2'd2; strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    checks++; if (cs !== 4'hF) begin errors++; $display("FAIL single_cs_e0: got %b want 1111", cs); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_e0: got %b want 1", busy); end
`ifdef SPI_TX_FIFO_EN
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready_e0: got %b want 1", ready); end
`else
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL single_ready_e0: got %b want 0", ready); end
`endif
    @(negedge clk);
    checks++; if (cs !== 4'b1011) begin errors++; $display("FAIL single_cs_e1: got %b want 1011", cs); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready_e1: got %b want 1", ready); end
    while (cs !== 4'hF && n < 60) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_gap: got %b want 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
    wait_frames(1, 5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_frame_seen: got %0d frames want 1", frames.size()); end
    if (frames.size() > 0) begin
      checks++; if (frames[0].len !== 36) begin errors++; $display("FAIL single_len: got %0d want 36", frames[0].len); end
      checks++; if (frames[0].nbits !== 8) begin errors++; $display("FAIL single_nbits: got %0d want 8", frames[0].nbits); end
      checks++; if (frames[0].bits !== 8'hA5) begin errors++; $display("FAIL single_bits: got %h want a5", frames[0].bits); end
    end
    checks++; if (glitches !== 0) begin errors++; $display("FAIL single_mosi_stable: got %0d glitches want 0", glitches); end
  endtask

  task automatic test_burst();
    logic [7:0] exp_words[$];
    bit exp_err;
    bit ok;
    int nstrobe;
    clear_mon();
`ifdef SPI_TX_FIFO_EN
    nstrobe = 6;
    exp_words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
`else
    nstrobe = 3;
    exp_words = '{8'h01, 8'h03};
`endif
    for (int i = 0; i < nstrobe; i++) begin
      data = 8'(i + 1); sel = 2'd0; strobe = 1'b1;
      @(negedge clk);
`ifdef SPI_TX_FIFO_EN
      exp_err = (i == 5);
`else
      exp_err = (i == 1);
`endif
      checks++; if (error !== exp_err) begin errors++; $display("FAIL burst_error_%0d: got %b want %b", i, error, exp_err); end
    end
    strobe = 1'b0;
    @(negedge clk);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL burst_error_pulse: got %b want 0", error); end
    wait_frames(exp_words.size(), 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_frames: got %0d want %0d", frames.size(), exp_words.size()); end
    for (int i = 0; i < exp_words.size(); i++) begin
      if (i < frames.size()) begin
        checks++; if (frames[i].bits !== exp_words[i]) begin errors++; $display("FAIL burst_bits_%0d: got %h want %h", i, frames[i].bits, exp_words[i]); end
        checks++; if (frames[i].cs !== 4'b1110) begin errors++; $display("FAIL burst_cs_%0d: got %b want 1110", i, frames[i].cs); end
        checks++; if (frames[i].len !== 36) begin errors++; $display("FAIL burst_len_%0d: got %0d want 36", i, frames[i].len); end
        if (i > 0) begin
          checks++; if (frames[i].gap !== 2) begin errors++; $display("FAIL burst_gap_%0d: got %0d want 2", i, frames[i].gap); end
        end
      end
    end
    repeat (10) @(negedge clk);
    checks++; if (frames.size() !== exp_words.size()) begin errors++; $display("FAIL burst_extra: got %0d frames want %0d", frames.size(), exp_words.size()); end
  endtask

  task automatic test_bad_sel();
    int bad = 0;
    data = 8'h55; sel = 2'd3; strobe3 = 1'b1;
    @(negedge clk);
    strobe3 = 1'b0;
    checks++; if (error3 !== 1'b1) begin errors++; $display("FAIL badsel_error: got %b want 1", error3); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL badsel_other_error: got %b want 0", error); end
    @(negedge clk);
    checks++; if (error3 !== 1'b0) begin errors++; $display("FAIL badsel_error_pulse: got %b want 0", error3); end
    for (int i = 0; i < 40; i++) begin
      if (cs3 !== 3'b111 || busy3 !== 1'b0 || ready3 !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL badsel_idle: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_sel_change();
    bit ok;
    clear_mon();
    data = 8'h3C; sel = 2'd0; strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    @(negedge clk); data = 8'hC3; sel = 2'd3; strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    wait_frames(2, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL selchg_frames: got %0d want 2", frames.size()); end
    if (frames.size() > 1) begin
      checks++; if (frames[0].cs !== 4'b1110) begin errors++; $display("FAIL selchg_cs0: got %b want 1110", frames[0].cs); end
      checks++; if (frames[0].bits !== 8'h3C) begin errors++; $display("FAIL selchg_bits0: got %h want 3c", frames[0].bits); end
      checks++; if (frames[1].cs !== 4'b0111) begin errors++; $display("FAIL selchg_cs1: got %b want 0111", frames[1].cs); end
      checks++; if (frames[1].bits !== 8'hC3) begin errors++; $display("FAIL selchg_bits1: got %h want c3", frames[1].bits); end
      checks++; if (frames[1].gap !== 2) begin errors++; $display("FAIL selchg_gap: got %0d want 2", frames[1].gap); end
      checks++; if (frames[1].len !== 36) begin errors++; $display("FAIL selchg_len: got %0d want 36", frames[1].len); end
    end
    checks++; if (multi_low !== 0) begin errors++; $display("FAIL selchg_onehot: got %0d violations want 0", multi_low); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int k = 0, rises = 0, active = 0;
    bit p = 1'b0;
    clear_mon();
    data = 8'hFF; sel = 2'd1; strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    @(negedge clk); data = 8'h81; sel = 2'd2; strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    @(negedge clk); data = 8'h42; sel = 2'd3; strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    while (rises < 4 && k < 60) begin
      if (sclk && !p) rises++;
      p = sclk;
      if (rises < 4) begin @(negedge clk); k++; end
    end
    checks++; if (rises !== 4) begin errors++; $display("FAIL rstmid_reach_bit4: got %0d rises want 4", rises); end
    checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL rstmid_mosi_before: got %b want 1", mosi); end
    rst = 1'b1; strobe = 1'b1; data = 8'h99; sel = 2'd0;
    @(negedge clk);
    checks++; if (cs !== 4'hF) begin errors++; $display("FAIL rstmid_cs: got %b want 1111", cs); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rstmid_sclk: got %b want 0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rstmid_mosi: got %b want 0", mosi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", ready); end
    @(negedge clk);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rstmid_error: got %b want 0", error); end
    rst = 1'b0; strobe = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cs !== 4'hF || busy !== 1'b0 || sclk !== 1'b0 || error !== 1'b0) active++;
    end
    checks++; if (active !== 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", active); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_bad_sel();
    test_sel_change();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_master_tx_multi_cs.md
# spi_master_tx_multi_cs

Parametrised SPI master transmitter. It takes words from the wave generator datapath (or any producer), buffers them, and shifts each one out MSB-first in SPI mode 0 to one of `NUM_CS` active-low chip selects, picked per word. It is the generalised successor of the single-CS, fixed-width TX master. It adds a configurable word width, SCLK divider, per-word slave selection, an input buffer with ready/busy flow control, and drop reporting.

## Interface
- `DATA_WIDTH`, 8: bits per SPI frame, ≥ 2.
- `NUM_CS`, 4: number of chip-select lines, ≥ 1.
- `CLK_DIV`, 2: SCLK half-period in `clk_i` cycles, ≥ 1.
- `FIFO_DEPTH`, 4: input FIFO entries, power of two ≥ 2. Used only with `SPI_TX_FIFO_EN`.
- `CS_SEL_W`, derived: `NUM_CS > 1 ? $clog2(NUM_CS) : 1`.

Ports:
- `clk_i`  in  1  system clock; all logic on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `data_i`  in  DATA_WIDTH  word to transmit
- `cs_sel_i`  in  CS_SEL_W  target chip select for `data_i`
- `data_in_valid_strobe_i`  in  1  one-cycle write strobe
- `ready_o`  out  1  storage not full; a strobe is accepted only when high
- `busy_o`  out  1  frame in progress or storage non-empty
- `error_o`  out  1  one-cycle pulse when a strobe is dropped
- `spi_clk_o`  out  1  SCLK; idle low
- `spi_mosi_o`  out  1  serial data, MSB first
- `spi_cs_o`  out  NUM_CS  active-low selects; at most one low

## Operation
- Write: if `data_in_valid_strobe_i` and `ready_o` and `cs_sel_i < NUM_CS`, then `{cs_sel_i, data_i}` is stored.
- Drops: a strobe while full, or with `cs_sel_i >= NUM_CS`, is discarded and pulses `error_o` on the next cycle. A write when full is rejected even if a pop happens in the same cycle.
- FSM states:
  - IDLE → SETUP when storage is non-empty. The word is popped, loaded into the shift register, `spi_cs_o[sel]` driven low and `spi_mosi_o` = MSB.
  - SETUP: `CLK_DIV` cycles with SCLK low.
  - SHIFT: `DATA_WIDTH` SCLK periods. Each has a high half of `CLK_DIV` cycles, then a low half of `CLK_DIV` cycles. MOSI advances to the next bit on each falling edge except the last.
  - HOLD: `CLK_DIV` cycles with CS still low and SCLK low.
  - GAP: all CS high for `CLK_DIV` cycles. Then go to SETUP directly if storage is non-empty (pop on that edge), otherwise to IDLE.
- Bit counter and divider counter are sized from their parameters. Wrap is never observable.
- `busy_o` = (state != IDLE) | non-empty.
- Reset (including mid-frame): on the reset edge
  - all `spi_cs_o` = 1, `spi_clk_o` = 0, `spi_mosi_o` = 0
  - storage flushed, state IDLE, `error_o` = 0, `busy_o` = 0, `ready_o` = 1
  - strobes while `rst_i` is high are ignored and never flagged.

## Timing
- Latency: a strobe accepted at edge E0 into empty storage with FSM in IDLE pulls CS low at edge E0+1.
- First SCLK rise is `CLK_DIV` cycles after CS falls. The slave samples on rising edges; MOSI is stable for the whole high half.
- Frame (CS low duration) = `CLK_DIV*(2*DATA_WIDTH+2)` cycles. With defaults, 36.
- Back-to-back frames: CS high exactly `CLK_DIV` cycles between them. A different `cs_sel` switches to the other line after the same gap.
- `ready_o` and `busy_o` are registered. `ready_o` reflects occupancy after the current edge's push/pop.

## Configuration
- `SPI_TX_FIFO_EN` defined: storage is a `FIFO_DEPTH`-entry circular FIFO with read/write pointers and a count.
- `SPI_TX_FIFO_EN` undefined: storage is a single holding register (depth 1). `FIFO_DEPTH` is ignored. `ready_o` = holding register empty.
- All other behaviour is identical in both builds.

## Test plan
Defaults unless stated; FIFO enabled unless stated.
- Single word: `0xA5`, sel 2 → `spi_cs_o` = `4'b1011` for 36 cycles; 8 SCLK rises; MOSI at rises = 1,0,1,0,0,1,0,1; `busy_o` falls 2 cycles after CS rises.
- Burst: 6 strobes on consecutive cycles, data `0x01`..`0x06` → first 5 accepted, 6th gives one `error_o` pulse. 5 frames go out in order, each separated by exactly 2 CS-high cycles.
- FIFO disabled, 3 strobes on consecutive cycles → words 1 and 3 transmitted, word 2 gives an `error_o` pulse.
- `NUM_CS`=3, strobe with sel 3 → `error_o` pulse, no CS activity, `busy_o` stays 0.
- Sel changes: `0x3C` on sel 0, then `0xC3` on sel 3 → CS0 low for the first frame, 2-cycle all-high gap, then CS3 low; `0xC3` bits correct.
- Reset asserted during the 4th SHIFT bit with 2 words queued → next edge: all CS high, SCLK 0, MOSI 0, `busy_o` 0, `ready_o` 1. No further frames.
